regfile_bist: RTL and testbench
===============================

REGFILE_BIST -- requirements
Module: regfile_bist

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the register data width in bits; it SHALL be even and at least 2.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of registers tested; it SHALL be 1..8.
REQ-003 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port START, input, 1 bit: request a test run; sampled in IDLE only.
REQ-006 The block SHALL have port ABORT, input, 1 bit: synchronous cancel of a run in progress.
REQ-007 The block SHALL have port PATTERN, input, 2 bits: data pattern select; latched when START is accepted.
REQ-008 The block SHALL have port RD, input, WIDTH bits: combinational read data returned by the register file for RA.
REQ-009 The block SHALL have port WA, output, 3 bits: register-file write address.
REQ-010 The block SHALL have port Din, output, WIDTH bits: register-file write data.
REQ-011 The block SHALL have port WR_ENABLE, output, 1 bit: register-file write strobe.
REQ-012 The block SHALL have port RA, output, 3 bits: register-file read address.
REQ-013 The block SHALL have port BUSY, output, 1 bit: run in progress.
REQ-014 The block SHALL have port DONE, output, 1 bit: run completed; results valid.
REQ-015 The block SHALL have port PASS, output, 1 bit: run completed with zero mismatches.
REQ-016 The block SHALL have port ERR_COUNT, output, 4 bits: mismatch count, saturating at 15.
REQ-017 The block SHALL have port FAIL_ADDR, output, 3 bits: address of the first mismatch; 0 if none.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, READ, FINISH; a 3-bit address counter ADDR SHALL step through 0..DEPTH-1 in WRITE and in READ.
REQ-019 IDLE with START=1 at an edge SHALL latch PATTERN, clear ERR_COUNT, FAIL_ADDR, DONE and PASS, set ADDR=0, and enter WRITE.
REQ-020 Expected data E(i) SHALL be: PATTERN 0 -> i zero-extended/truncated to WIDTH; 1 -> bitwise inverse of that; 2 -> all ones; 3 -> alternating bits with bit0=1 for even i and bit0=0 for odd i.
REQ-021 In WRITE, outputs SHALL be WR_ENABLE=1, WA=ADDR and Din=E(ADDR), giving exactly one write per cycle for DEPTH cycles.
REQ-022 WRITE with ADDR=DEPTH-1 SHALL move to READ with ADDR=0.
REQ-023 In READ, outputs SHALL be WR_ENABLE=0 and RA=ADDR, and RD SHALL be compared with E(ADDR) at each edge (zero-latency read).
REQ-024 On a READ mismatch, ERR_COUNT SHALL increment, saturating at 15; on the first mismatch of a run, FAIL_ADDR SHALL be set to ADDR.
REQ-025 READ with ADDR=DEPTH-1 SHALL evaluate the final compare and then move to FINISH.
REQ-026 In FINISH, DONE=1 and PASS=(ERR_COUNT==0) SHALL hold until the next accepted START, and FINISH SHALL accept START exactly as IDLE does.
REQ-027 BUSY SHALL be 1 exactly in WRITE and READ; a run SHALL take 2*DEPTH busy cycles, with DONE high on the cycle after the last READ cycle.
REQ-028 START while BUSY SHALL be ignored.
REQ-029 ABORT=1 in WRITE or READ SHALL go to IDLE at the next edge with DONE=0 and PASS=0; ABORT SHALL take priority over START and over the ADDR terminal transition.
REQ-030 Outside WRITE, WA, Din and WR_ENABLE SHALL be 0; outside READ, RA SHALL be 0.

Reset
REQ-031 While RST=0, the block SHALL immediately force IDLE, ADDR=0, WR_ENABLE=0, WA=0, Din=0, RA=0, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0 and FAIL_ADDR=0, independent of CLK.
REQ-032 RST asserted mid-run SHALL end the run with no further write strobes; after release, the block SHALL wait in IDLE for START.

Verification
REQ-033 Test 1: with WIDTH=4 and DEPTH=8, ideal regfile model, PATTERN=0 and a 1-cycle START -> WA 0..7 with Din 0..7 and WR_ENABLE high for 8 cycles, then RA 0..7, BUSY for 16 cycles, and DONE=1, PASS=1, ERR_COUNT=0.
REQ-034 Test 2: PATTERN=3 with register 5 stuck at 4'h0 -> Din=4'h5 at even and 4'hA at odd addresses, ERR_COUNT=1, FAIL_ADDR=5, PASS=0.
REQ-035 Test 3: PATTERN=2 with RD forced to 4'h0 -> ERR_COUNT=8, FAIL_ADDR=0, PASS=0; a second run with RD correct -> ERR_COUNT=0, PASS=1.
REQ-036 Test 4: ABORT on the 3rd READ cycle, with START also high -> IDLE next cycle, BUSY=0, DONE=0, WR_ENABLE=0; a later START runs a full 16-cycle test.
REQ-037 Test 5: RST low asynchronously mid-WRITE at ADDR=4 -> all outputs 0 before the next CLK edge; START pulses during BUSY -> no restart and no change in cycle count.

Source files
------------

// File: rtl/regfile_bist.sv
// Register-file BIST: writes a selectable pattern to DEPTH registers, reads it back and counts mismatches.
// Latency: a run takes 2*DEPTH busy cycles; DONE/PASS are valid on the cycle after the last read.
// No backpressure: one write or one compare per cycle; ABORT cancels a run, and START is ignored while busy.
module regfile_bist #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [1:0]       PATTERN,
    input  logic [WIDTH-1:0] RD,
    output logic [2:0]       WA,
    output logic [WIDTH-1:0] Din,
    output logic             WR_ENABLE,
    output logic [2:0]       RA,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [3:0]       ERR_COUNT,
    output logic [2:0]       FAIL_ADDR
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

    localparam logic [2:0] LAST = 3'(DEPTH - 1);

    state_t           state;
    logic [2:0]       addr;
    logic [1:0]       pat;
    logic [WIDTH-1:0] exp_rd;
    logic             mismatch;

    // Expected register contents for address i under pattern pat.
    function automatic logic [WIDTH-1:0] exp_data(input logic [1:0] p, input logic [2:0] i);
        logic [WIDTH-1:0] v;
        v = '0;
        case (p)
            2'd0:    v = WIDTH'(i);
            2'd1:    v = ~WIDTH'(i);
            2'd2:    v = '1;
            default: begin
                // Checkerboard: bit0 set on even addresses, cleared on odd ones.
                for (int b = 0; b < WIDTH; b++) begin
                    v[b] = ((b % 2) == 0) ? ~i[0] : i[0];
                end
            end
        endcase
        return v;
    endfunction

    // Zero-latency read check: RD answers the RA we present this cycle, and RA equals addr in READ.
    assign exp_rd   = exp_data(pat, addr);
    assign mismatch = (RD != exp_rd);

    // Single FSM with every output registered so the register-file interface is glitch-free.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            addr      <= '0;
            pat       <= '0;
            WA        <= '0;
            Din       <= '0;
            WR_ENABLE <= 1'b0;
            RA        <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_COUNT <= '0;
            FAIL_ADDR <= '0;
        end else if (ABORT && (state == WRITE || state == READ)) begin
            // Abort outranks both START and the terminal-address transition.
            state     <= IDLE;
            addr      <= '0;
            WA        <= '0;
            Din       <= '0;
            WR_ENABLE <= 1'b0;
            RA        <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (START) begin
                        // First write is presented on the very next cycle, using the live PATTERN.
                        state     <= WRITE;
                        pat       <= PATTERN;
                        addr      <= '0;
                        ERR_COUNT <= '0;
                        FAIL_ADDR <= '0;
                        DONE      <= 1'b0;
                        PASS      <= 1'b0;
                        BUSY      <= 1'b1;
                        WR_ENABLE <= 1'b1;
                        WA        <= '0;
                        Din       <= exp_data(PATTERN, 3'd0);
                    end
                end
                WRITE: begin
                    if (addr == LAST) begin
                        state     <= READ;
                        addr      <= '0;
                        WR_ENABLE <= 1'b0;
                        WA        <= '0;
                        Din       <= '0;
                        RA        <= '0;
                    end else begin
                        addr      <= addr + 3'd1;
                        WA        <= addr + 3'd1;
                        Din       <= exp_data(pat, addr + 3'd1);
                    end
                end
                READ: begin
                    if (mismatch) begin
                        if (ERR_COUNT != 4'd15) begin
                            ERR_COUNT <= ERR_COUNT + 4'd1;
                        end
                        // The count only grows, so zero means this is the run's first miss.
                        if (ERR_COUNT == 4'd0) begin
                            FAIL_ADDR <= addr;
                        end
                    end
                    if (addr == LAST) begin
                        state <= FINISH;
                        addr  <= '0;
                        RA    <= '0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= (ERR_COUNT == 4'd0) && !mismatch;
                    end else begin
                        addr  <= addr + 3'd1;
                        RA    <= addr + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: a register-file model answers reads combinationally, with optional faults.
// Stimulus pushes expected writes, reads and results; a negedge monitor pops and compares them.
// Directed runs cover the patterns, fault cases, abort, asynchronous reset and ignored START.
module tb_regfile_bist;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       ABORT;
    logic [1:0] PATTERN;
    logic [3:0] RD;
    logic [2:0] WA;
    logic [3:0] Din;
    logic       WR_ENABLE;
    logic [2:0] RA;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [3:0] ERR_COUNT;
    logic [2:0] FAIL_ADDR;

    regfile_bist #(.WIDTH(4), .DEPTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .ABORT     (ABORT),
        .PATTERN   (PATTERN),
        .RD        (RD),
        .WA        (WA),
        .Din       (Din),
        .WR_ENABLE (WR_ENABLE),
        .RA        (RA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .PASS      (PASS),
        .ERR_COUNT (ERR_COUNT),
        .FAIL_ADDR (FAIL_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hand-computed write data per pattern and address.
    localparam logic [3:0] DIN_TAB [4][8] = '{
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7},
        '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8},
        '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF},
        '{4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA}
    };

    typedef struct packed {
        logic [2:0] a;
        logic [3:0] d;
    } wr_t;

    typedef struct packed {
        logic [3:0] err;
        logic [2:0] fail;
        logic       pass;
    } res_t;

    wr_t        wq[$];
    logic [2:0] rq[$];
    res_t       resq[$];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int fault = 0;      // 0 ideal, 1 register 5 reads 0, 2 every read returns 0
    logic done_q = 1'b0;
    logic [3:0] mem [8];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Register file model: synchronous write, combinational read with injectable faults.
    always @(posedge CLK) begin
        if (WR_ENABLE) mem[WA] <= Din;
    end

    always_comb begin
        RD = mem[RA];
        if (fault == 1 && RA == 3'd5) RD = 4'h0;
        if (fault == 2) RD = 4'h0;
    end

    // Monitor: compare each observed write, read address and completed result against the queues.
    always @(negedge CLK) begin
        if (RST) begin
            if (BUSY) busy_cnt++;
            if (WR_ENABLE) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write WA=%0d Din=%0h expected no write", WA, Din);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("wa", int'(WA), int'(w.a));
                    check("din", int'(Din), int'(w.d));
                end
            end
            if (BUSY && !WR_ENABLE) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read RA=%0d expected no read", RA);
                end else begin
                    check("ra", int'(RA), int'(rq.pop_front()));
                end
            end
            if (DONE && !done_q) begin
                if (resq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done ERR_COUNT=%0d expected no completion", ERR_COUNT);
                end else begin
                    res_t r;
                    r = resq.pop_front();
                    check("err_count", int'(ERR_COUNT), int'(r.err));
                    check("fail_addr", int'(FAIL_ADDR), int'(r.fail));
                    check("pass", int'(PASS), int'(r.pass));
                end
            end
        end
        done_q = DONE;
    end

    task automatic push_run(input int pat, input int nw, input int nr, input bit has_res,
                            input int err, input int fail, input int pass);
        for (int i = 0; i < nw; i++) wq.push_back(wr_t'{a: 3'(i), d: DIN_TAB[pat][i]});
        for (int i = 0; i < nr; i++) rq.push_back(3'(i));
        if (has_res) resq.push_back(res_t'{err: 4'(err), fail: 3'(fail), pass: pass[0]});
    endtask

    // Pulse START for one edge; returns just after the accepting edge.
    task automatic run_start(input logic [1:0] pat);
        @(posedge CLK); #1;
        START = 1'b1;
        PATTERN = pat;
        busy_cnt = 0;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, int'(ok), 1);
        check({name, "_busy_cycles"}, busy_cnt, 16);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'h0;
        RST = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        PATTERN = 2'd0;
        #12;
        check("rst_busy", int'(BUSY), 0);
        check("rst_wr_enable", int'(WR_ENABLE), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_err_count", int'(ERR_COUNT), 0);
        RST = 1'b1;

        // Test 1: pattern 0, ideal register file.
        push_run(0, 8, 8, 1, 0, 0, 1);
        run_start(2'd0);
        wait_done("t1_done");

        // Test 2: checkerboard with register 5 stuck at zero.
        fault = 1;
        push_run(3, 8, 8, 1, 1, 5, 0);
        run_start(2'd3);
        wait_done("t2_done");

        // Test 3: all ones with every read forced low, then a clean rerun.
        fault = 2;
        push_run(2, 8, 8, 1, 8, 0, 0);
        run_start(2'd2);
        wait_done("t3a_done");
        fault = 0;
        push_run(2, 8, 8, 1, 0, 0, 1);
        run_start(2'd2);
        wait_done("t3b_done");

        // Inverted pattern, clean.
        push_run(1, 8, 8, 1, 0, 0, 1);
        run_start(2'd1);
        wait_done("p1_done");

        // Test 4: ABORT together with START on the third read cycle.
        push_run(0, 8, 3, 0, 0, 0, 0);
        run_start(2'd0);
        repeat (10) @(posedge CLK);
        #1;
        ABORT = 1'b1;
        START = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        START = 1'b0;
        check("abort_busy", int'(BUSY), 0);
        check("abort_done", int'(DONE), 0);
        check("abort_wr_enable", int'(WR_ENABLE), 0);
        check("abort_pass", int'(PASS), 0);
        check("abort_rq_drained", rq.size(), 0);
        push_run(0, 8, 8, 1, 0, 0, 1);
        run_start(2'd0);
        wait_done("t4_done");

        // Test 5: asynchronous reset while WA=4 is on the bus, between clock edges.
        push_run(0, 5, 0, 0, 0, 0, 0);
        run_start(2'd0);
        repeat (4) @(posedge CLK);
        #7;
        RST = 1'b0;
        #1;
        check("arst_wa", int'(WA), 0);
        check("arst_din", int'(Din), 0);
        check("arst_wr_enable", int'(WR_ENABLE), 0);
        check("arst_busy", int'(BUSY), 0);
        check("arst_ra", int'(RA), 0);
        check("arst_wq_drained", wq.size(), 0);
        #1;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_idle", int'(BUSY || WR_ENABLE || DONE), 0);

        // START pulses while busy must neither restart nor stretch the run.
        push_run(1, 8, 8, 1, 0, 0, 1);
        run_start(2'd1);
        repeat (3) @(posedge CLK);
        #1;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done("t5_done");
        repeat (3) @(negedge CLK);
        check("finish_holds_done", int'(DONE), 1);

        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        check("resq_empty", resq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
